pwm_duty_ramp_controller: RTL

Sequencer that drives the 2-bit `duty_cycle` input of the 4-phase PWM generator. It accepts a target duty through a valid/ready handshake and ramps the generator's duty one step per programmable number of PWM periods, so the output never jumps directly between duty levels. Duty changes only take effect on PWM period boundaries, so the generator never emits a truncated or glitched pulse. It sits between the system command logic and the PWM generator, and shares the generator's clock and reset.

---
 rtl/pwm_duty_ramp_controller.sv | 114 +++++++++++
 1 files changed

// File: rtl/pwm_duty_ramp_controller.sv
// pwm_duty_ramp_controller
// Ramps the 2-bit duty_cycle of a 4-phase PWM generator toward a commanded
// target, one step per HOLD_PERIODS PWM periods. Steps are applied only on
// period boundaries (phase == 3), so the generator first uses a new duty at
// phase 0 and never emits a truncated pulse.
//
// Ports:
//   clk           system clock, shared with the PWM generator
//   reset         asynchronous active-high reset, shared with the generator
//   cmd_valid     a target duty is offered
//   cmd_duty      target duty (0..3 = 0/25/50/75 %)
//   cmd_ready     command can be accepted (idle and not stopped)
//   stop          synchronous abort; freezes the ramp at the current duty
//   duty_cycle    registered duty to the generator
//   period_start  high while the internal phase is 0
//   busy          high while ramping
//   done          one-cycle pulse when the target duty has been reached
//
// state  | meaning
// S_IDLE | waiting for a command; duty_cycle held
// S_RAMP | stepping duty_cycle toward target on period boundaries
module pwm_duty_ramp_controller #(
  parameter int HOLD_PERIODS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_duty,
  output logic       cmd_ready,
  input  logic       stop,
  output logic [1:0] duty_cycle,
  output logic       period_start,
  output logic       busy,
  output logic       done
);

  typedef enum logic {S_IDLE, S_RAMP} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_PERIODS - 1);

  state_t     state, state_nxt;
  logic [1:0] phase;
  logic [1:0] target;
  logic [7:0] hold_cnt;
  logic       boundary;
  logic       accept;
  logic       ramp_edge;
  logic       step_now;
  logic [1:0] duty_stepped;

  // phase mirrors the generator's period counter: same reset, same increment
  assign boundary     = (phase == 2'd3);
  assign accept       = cmd_valid & cmd_ready;
  // stop wins over a boundary that lands on the same edge
  assign ramp_edge    = (state == S_RAMP) & ~stop & boundary;
  assign step_now     = ramp_edge & (hold_cnt == HOLD_LAST);
  // only meaningful while target != duty_cycle, which RAMP guarantees
  assign duty_stepped = (target > duty_cycle) ? duty_cycle + 2'd1 : duty_cycle - 2'd1;
  assign period_start = (phase == 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && (cmd_duty != duty_cycle)) state_nxt = S_RAMP;
      S_RAMP: begin
        if (stop)                                     state_nxt = S_IDLE;
        else if (step_now && (duty_stepped == target)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: cmd_ready = ~stop;
      S_RAMP: busy      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= 2'd0;
      duty_cycle <= 2'd0;
      target     <= 2'd0;
      hold_cnt   <= 8'd0;
      done       <= 1'b0;
    end else begin
      phase <= phase + 2'd1;
      done  <= 1'b0;
      if (accept) begin
        target   <= cmd_duty;
        hold_cnt <= 8'd0;
        if (cmd_duty == duty_cycle) done <= 1'b1;
      end else if (ramp_edge) begin
        if (step_now) begin
          duty_cycle <= duty_stepped;
          hold_cnt   <= 8'd0;
          if (duty_stepped == target) done <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 8'd1;
        end
      end
    end
  end

endmodule
